// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU arbiter: FSM states, ALUControl encodings, NZCV bit positions.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu.sv
// N-bit ALU: ADD/SUB/AND/OR with NZCV flags; SUB is a + ~b + 1 so C=1 means no borrow.
module alu #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [1:0]   alucontrol,
  output logic [N-1:0] result,
  output logic [3:0]   aluflags
);
  import alu_arb_pkg::*;

  logic [N-1:0] b_mux;
  logic [N:0]   sum;
  logic         is_arith;
  logic         carry;
  logic         overflow;

  assign b_mux    = alucontrol[0] ? ~b : b;
  assign sum      = {1'b0, a} + {1'b0, b_mux} + {{N{1'b0}}, alucontrol[0]};
  assign is_arith = ~alucontrol[1];

  always_comb begin
    result = sum[N-1:0];
    case (alucontrol)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      default: result = sum[N-1:0];
    endcase
  end

  // Overflow: operands effectively share a sign and the sum's sign differs from a.
  assign carry    = is_arith & sum[N];
  assign overflow = is_arith & ~(a[N-1] ^ b[N-1] ^ alucontrol[0]) & (a[N-1] ^ sum[N-1]);
  assign aluflags = {result[N-1], ~|result, carry, overflow};

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
  parameter  int NREQ = 2,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            any_valid
);

  assign any_valid = |req;

  // Scan from the farthest offset down so the nearest valid index wins.
  always_comb begin
    grant_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % NREQ]) begin
        grant_idx = IDW'((int'(ptr) + i) % NREQ);
      end
    end
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_grant
    assign grant[gi] = any_valid && (grant_idx == IDW'(gi));
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between NREQ requesters with a tagged, registered response.
// Define ALU_ARB_FLAGREG_EN to keep per-requester last flags on flags_q; otherwise flags_q is 0.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter  int N    = 32,
  parameter  int NREQ = 2,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  input  logic [NREQ*2-1:0] req_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [N-1:0]      rsp_result,
  output logic [3:0]        rsp_flags,
  output logic [NREQ*4-1:0] flags_q
);

  state_t          state_reg, state_next;
  logic [IDW-1:0]  rr_ptr_reg;
  logic [N-1:0]    op_a_reg, op_b_reg;
  logic [1:0]      op_sel_reg;
  logic [IDW-1:0]  id_reg;
  logic [IDW-1:0]  rsp_id_reg;
  logic [N-1:0]    rsp_result_reg;
  logic [3:0]      rsp_flags_reg;

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_idx;
  logic            any_valid;
  logic            accept;
  logic            rsp_fire;
  logic [N-1:0]    alu_result;
  logic [3:0]      alu_flags;
  logic [3:0]      flags_next;
  logic            unused_alu_nz;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req       (req_valid),
    .ptr       (rr_ptr_reg),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_valid (any_valid)
  );

  alu #(.N(N)) u_alu (
    .a          (op_a_reg),
    .b          (op_b_reg),
    .alucontrol (op_sel_reg),
    .result     (alu_result),
    .aluflags   (alu_flags)
  );

  // N and Z come from the result itself; only C and V need the adder internals.
  assign flags_next    = {alu_result[N-1], (alu_result == '0), alu_flags[FLAG_C], alu_flags[FLAG_V]};
  assign unused_alu_nz = alu_flags[FLAG_N] ^ alu_flags[FLAG_Z];

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (any_valid) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = 1'b0;
    if (state_reg == IDLE) req_ready = grant;
    if (state_reg == RESP) rsp_valid = 1'b1;
  end

  assign accept   = (state_reg == IDLE) && any_valid;
  assign rsp_fire = rsp_valid && rsp_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_reg     <= '0;
      op_a_reg       <= '0;
      op_b_reg       <= '0;
      op_sel_reg     <= '0;
      id_reg         <= '0;
      rsp_id_reg     <= '0;
      rsp_result_reg <= '0;
      rsp_flags_reg  <= '0;
    end else begin
      if (accept) begin
        op_a_reg   <= req_a[grant_idx*N +: N];
        op_b_reg   <= req_b[grant_idx*N +: N];
        op_sel_reg <= req_op[grant_idx*2 +: 2];
        id_reg     <= grant_idx;
        rr_ptr_reg <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
      end
      if (state_reg == EXEC) begin
        rsp_result_reg <= alu_result;
        rsp_flags_reg  <= flags_next;
        rsp_id_reg     <= id_reg;
      end
    end
  end

  assign rsp_id     = rsp_id_reg;
  assign rsp_result = rsp_result_reg;
  assign rsp_flags  = rsp_flags_reg;

`ifdef ALU_ARB_FLAGREG_EN
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_flagreg
    logic [3:0] flags_reg;
    always_ff @(posedge clk) begin
      if (reset) flags_reg <= '0;
      else if (rsp_fire && (rsp_id_reg == IDW'(gi))) flags_reg <= rsp_flags_reg;
    end
    assign flags_q[gi*4 +: 4] = flags_reg;
  end
`else
  logic unused_rsp_fire;
  assign unused_rsp_fire = rsp_fire;
  assign flags_q         = '0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized self-checking bench for alu_arbiter against a spec-level arithmetic and round-robin model.
module tb_alu_arbiter;
  localparam int N    = 32;
  localparam int NREQ = 2;
  localparam int IDW  = 1;

  logic              clk;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic [NREQ*2-1:0] req_op;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [N-1:0]      rsp_result;
  logic [3:0]        rsp_flags;
  logic [NREQ*4-1:0] flags_q;

  alu_arbiter #(.N(N), .NREQ(NREQ)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags),
    .flags_q    (flags_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         mptr;
  int         last_grant;
  logic [3:0] mflags [NREQ];
  logic [N-1:0] opa [NREQ];
  logic [N-1:0] opb [NREQ];
  logic [1:0]   opc [NREQ];

  // Reference ALU from plain wide arithmetic: returns {N,Z,C,V, result}.
  function automatic logic [N+3:0] ref_alu(input logic [N-1:0] a, input logic [N-1:0] b, input logic [1:0] op);
    longint ua, ub, sa, sb, s, maxs, mins;
    logic [N-1:0] res;
    logic c, v;
    ua = longint'(a);  ub = longint'(b);
    sa = longint'($signed(a));  sb = longint'($signed(b));
    maxs = (longint'(1) <<< (N - 1)) - 1;
    mins = -(longint'(1) <<< (N - 1));
    c = 1'b0;  v = 1'b0;  res = '0;
    case (op)
      2'b00: begin
        s = ua + ub;  res = s[N-1:0];  c = s[N];
        s = sa + sb;  v = (s > maxs) || (s < mins);
      end
      2'b01: begin
        res = a - b;  c = (ua >= ub);
        s = sa - sb;  v = (s > maxs) || (s < mins);
      end
      2'b10: res = a & b;
      default: res = a | b;
    endcase
    return {res[N-1], (res == '0), c, v, res};
  endfunction

  function automatic int model_grant(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) begin
      if (v[(mptr + i) % NREQ]) return (mptr + i) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [NREQ*4-1:0] model_flags_q();
    logic [NREQ*4-1:0] e;
    e = '0;
`ifdef ALU_ARB_FLAGREG_EN
    for (int i = 0; i < NREQ; i++) e[i*4 +: 4] = mflags[i];
`endif
    return e;
  endfunction

  task automatic drive_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*N +: N] = opa[i];
      req_b[i*N +: N] = opb[i];
      req_op[i*2 +: 2] = opc[i];
    end
  endtask

  task automatic check_flags_q(input string tag);
    logic [NREQ*4-1:0] e;
    e = model_flags_q();
    checks++;
    if (flags_q !== e) begin
      errors++;
      $display("FAIL %s flags_q got %h want %h", tag, flags_q, e);
    end
  endtask

  // One full accept/exec/response transaction with rsp_ready high; starts and ends at posedge+1.
  task automatic txn(input logic [NREQ-1:0] v, input logic hold, input string tag);
    int g;
    logic [N+3:0] e;
    logic [NREQ-1:0] erdy;
    req_valid = v;
    drive_ops();
    #1;
    g = model_grant(v);
    erdy = '0;
    if (g >= 0) erdy[g] = 1'b1;
    checks++;
    if (req_ready !== erdy) begin
      errors++;
      $display("FAIL %s accept req_ready got %b want %b", tag, req_ready, erdy);
    end
    last_grant = g;
    if (g < 0) begin
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s idle rsp_valid got %b want 0", tag, rsp_valid);
      end
      return;
    end
    e = ref_alu(opa[g], opb[g], opc[g]);
    mptr = (g + 1) % NREQ;
    @(posedge clk); #1;
    if (!hold) req_valid = '0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== '0) begin
      errors++;
      $display("FAIL %s exec rsp_valid %b req_ready %b want 0/0", tag, rsp_valid, req_ready);
    end
    @(posedge clk); #1;
    $display("txn %s id=%0d a=%h b=%h op=%b -> result=%h flags=%b", tag, g, opa[g], opb[g], opc[g], rsp_result, rsp_flags);
    checks++;
    if (rsp_valid !== 1'b1 || req_ready !== '0 || rsp_id !== IDW'(g) ||
        rsp_result !== e[N-1:0] || rsp_flags !== e[N+3:N]) begin
      errors++;
      $display("FAIL %s resp valid=%b rdy=%b id=%0d res=%h flg=%b want 1/0/%0d/%h/%b",
               tag, rsp_valid, req_ready, rsp_id, rsp_result, rsp_flags, g, e[N-1:0], e[N+3:N]);
    end
    mflags[g] = e[N+3:N];
    @(posedge clk); #1;
    check_flags_q(tag);
  endtask

  task automatic test_reset();
    reset = 1'b1;  req_valid = '0;  rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      opa[i] = '0;  opb[i] = '0;  opc[i] = '0;  mflags[i] = '0;
    end
    drive_ops();
    mptr = 0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if (req_ready !== '0 || rsp_valid !== 1'b0 || rsp_id !== '0 || rsp_result !== '0 ||
        rsp_flags !== '0 || flags_q !== '0) begin
      errors++;
      $display("FAIL reset outputs rdy=%b vld=%b id=%0d res=%h flg=%b fq=%h want all 0",
               req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags, flags_q);
    end
  endtask

  task automatic test_add();
    opa[0] = 32'h7FFF_FFFF;  opb[0] = 32'h1;  opc[0] = 2'b00;
    txn(2'b01, 1'b0, "add_ovf");
  endtask

  task automatic test_sub();
    opa[1] = 32'd5;  opb[1] = 32'd5;  opc[1] = 2'b01;
    txn(2'b10, 1'b0, "sub_zero");
  endtask

  task automatic test_round_robin();
    int cnt [NREQ];
    int prev;
    for (int i = 0; i < NREQ; i++) cnt[i] = 0;
    prev = -1;
    opc[0] = 2'b10;  opc[1] = 2'b11;
    for (int k = 0; k < 2 * NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        opa[i] = $urandom;  opb[i] = $urandom;
      end
      txn(2'b11, 1'b1, "rr");
      if (last_grant >= 0) cnt[last_grant]++;
      checks++;
      if (last_grant == prev) begin
        errors++;
        $display("FAIL rr_alternate grant %0d repeated", last_grant);
      end
      prev = last_grant;
    end
    req_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      checks++;
      if (cnt[i] != 2) begin
        errors++;
        $display("FAIL rr_fair requester %0d grants %0d want 2", i, cnt[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int g;
    logic [N+3:0] e;
    opa[0] = 32'hDEAD_BEEF;  opb[0] = 32'h1234_5678;  opc[0] = 2'b01;
    opa[1] = 32'h0F0F_0F0F;  opb[1] = 32'hF0F0_0000;  opc[1] = 2'b00;
    rsp_ready = 1'b0;
    req_valid = 2'b11;
    drive_ops();
    #1;
    g = model_grant(2'b11);
    e = ref_alu(opa[g], opb[g], opc[g]);
    mptr = (g + 1) % NREQ;
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (rsp_valid !== 1'b1 || req_ready !== '0 || rsp_id !== IDW'(g) ||
          rsp_result !== e[N-1:0] || rsp_flags !== e[N+3:N]) begin
        errors++;
        $display("FAIL stall cyc %0d vld=%b rdy=%b id=%0d res=%h flg=%b want 1/0/%0d/%h/%b",
                 c, rsp_valid, req_ready, rsp_id, rsp_result, rsp_flags, g, e[N-1:0], e[N+3:N]);
      end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    mflags[g] = e[N+3:N];
    @(posedge clk); #1;
    $display("txn stall id=%0d released result=%h flags=%b", g, e[N-1:0], e[N+3:N]);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== (NREQ'(1) << mptr)) begin
      errors++;
      $display("FAIL stall_release vld=%b rdy=%b want 0/%b", rsp_valid, req_ready, NREQ'(1) << mptr);
    end
    req_valid = '0;
    check_flags_q("stall_release");
  endtask

  task automatic test_reset_mid_op();
    opa[1] = 32'd100;  opb[1] = 32'd7;  opc[1] = 2'b00;
    req_valid = 2'b10;
    drive_ops();
    @(posedge clk); #1;
    req_valid = '0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    mptr = 0;
    for (int i = 0; i < NREQ; i++) mflags[i] = '0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== '0) begin
      errors++;
      $display("FAIL midreset vld=%b rdy=%b want 0/0", rsp_valid, req_ready);
    end
    check_flags_q("midreset");
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL midreset_discard cyc %0d rsp_valid got %b want 0", c, rsp_valid);
      end
    end
    opa[0] = 32'hFFFF_FFFF;  opb[0] = 32'h1;  opc[0] = 2'b00;
    txn(2'b11, 1'b0, "post_reset");
    checks++;
    if (last_grant != 0) begin
      errors++;
      $display("FAIL post_reset_grant got %0d want 0", last_grant);
    end
  endtask

  task automatic test_flagreg();
    opa[1] = 32'd3;  opb[1] = 32'd5;  opc[1] = 2'b01;
    txn(2'b10, 1'b0, "flag_sub");
  endtask

  task automatic test_random();
    logic [N-1:0] pool [5];
    logic [NREQ-1:0] v;
    pool[0] = '0;  pool[1] = '1;  pool[2] = 32'h8000_0000;  pool[3] = 32'h7FFF_FFFF;
    for (int k = 0; k < 40; k++) begin
      pool[4] = $urandom;
      for (int i = 0; i < NREQ; i++) begin
        opa[i] = pool[$urandom_range(0, 4)];
        opb[i] = pool[$urandom_range(0, 4)];
        opc[i] = 2'($urandom_range(0, 3));
      end
      v = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      txn(v, 1'($urandom_range(0, 1)), "rand");
      req_valid = '0;
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_round_robin();
    test_backpressure();
    test_reset_mid_op();
    test_flagreg();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
